addsub_sat_seq: RTL and testbench
=================================

Name: addsub_sat_seq

Overview:
- Parametrised, multi-cycle saturating adder/subtractor for the datapath.
- Computes A+B or A-B over WIDTH bits, SLICE bits per clock, rippling the carry between slices through a register.
- Result is optionally saturated on signed overflow. Flags are produced for the ALU/flag register.
- Start/busy/done handshake lets the control unit stall on it.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of SLICE and >= SLICE.
- SLICE, 4, bits processed per cycle. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  clock, rising edge active
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0=add, 1=subtract (A-B); sampled with start
- sat_en  input  1  1=saturate on overflow, 0=wrap; sampled with start
- A  input  WIDTH  operand A, two's complement; sampled with start
- B  input  WIDTH  operand B, two's complement; sampled with start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; result and flags valid
- Sum  output  WIDTH  result, held until the next done
- Ovfl  output  1  signed overflow, before saturation
- Carry  output  1  raw carry out of MSB (for sub: 1 = no borrow)
- Zero  output  1  Sum == 0, after saturation
- Neg  output  1  Sum[WIDTH-1], after saturation

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy, done, Sum, Ovfl, Carry, Zero, Neg all 0; internal registers cleared.
- States: IDLE, RUN, FIN.
- IDLE (busy=0):
  - start=1 at an edge latches A, Bx = B ^ {WIDTH{sub}}, carry register = sub, sub/sat_en, slice counter = 0.
  - Then -> RUN.
- RUN (busy=1):
  - Each edge adds slice i of A, slice i of Bx and the carry register.
  - Writes the SLICE-bit result into slice i of the internal result and updates the carry register.
  - On the last slice, also records the carry into the MSB (c_msb) and the carry out (c_out).
  - After NSLICE edges -> FIN.
- FIN (busy=1), exactly one edge:
  - Ovfl = c_msb ^ c_out.
  - If Ovfl and sat_en: Sum = 0111..1 when A[MSB]=0, or 1000..0 when A[MSB]=1. The overflow direction follows A's sign because the effective operand signs are equal.
  - Otherwise Sum = raw result.
  - Carry = c_out; Zero and Neg are computed from the final Sum.
  - done=1 for that cycle only, then -> IDLE.
- Latency: with start sampled at edge 0, done is high in the cycle following edge NSLICE+1. The next start can be sampled at the edge that ends the done cycle.
- Throughput: one operation per NSLICE+2 cycles.
- start while busy=1 is ignored; the latched operands are not disturbed.
- Sum and flags change only on the FIN edge or on reset.
- Arithmetic: the full-width two's-complement identity A + ~B + 1 is used for sub. B = most-negative value is handled by the normal ripple, with no special case.
- Ovfl is reported regardless of sat_en.
- Reset mid-operation: aborts immediately; done never pulses for the aborted operation; outputs go to their reset values.
- Operand/mode inputs are don't-care except at the accepting edge.

Test Plan (WIDTH=16, SLICE=4 unless noted; done expected 5 edges after start):
- Add 0x1234+0x0101, sat_en=1 -> Sum=0x1335, Ovfl=0, Carry=0, Zero=0, Neg=0; done exactly once; busy high for 5 cycles.
- Positive overflow:
  - Add 0x7FFF+0x0001, sat_en=1 -> Sum=0x7FFF, Ovfl=1, Neg=0.
  - Same with sat_en=0 -> Sum=0x8000, Ovfl=1, Neg=1.
  - Add 0xFFFF+0x0001 -> Sum=0x0000, Carry=1, Zero=1, Ovfl=0.
- Subtract saturation:
  - 0x8000-0x0001, sat_en=1 -> Sum=0x8000, Ovfl=1.
  - 0x0000-0x8000, sat_en=1 -> Sum=0x7FFF, Ovfl=1.
  - 0x0005-0x0005 -> Sum=0x0000, Zero=1, Carry=1.
- Handshake and reset:
  - Start 0x0001+0x0001, then assert start with 0x7000+0x7000 two cycles later -> second request ignored; Sum=0x0002; single done.
  - New start on the edge ending done -> accepted; back-to-back results correct.
  - Drive rst_n low during RUN cycle 2 -> busy=0 and Sum=0 immediately; no done pulse.
- WIDTH=4, SLICE=4: 0x7+0x1, sat_en=1 -> Sum=0x7, Ovfl=1; done 2 edges after start.
- WIDTH=8, SLICE=2: 0x80+0xFF, sat_en=1 -> Sum=0x80, Ovfl=1, Carry=1.

Source files
------------

// File: rtl/addsub_sat_seq.sv
// addsub_sat_seq: multi-cycle saturating adder/subtractor.
// Processes SLICE bits per clock and ripples the carry between slices through a register.
// Reports Ovfl, Carry, Zero and Neg, and uses a start/busy/done handshake.
module addsub_sat_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             sat_en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Carry,
  output logic             Zero,
  output logic             Neg
);

  // WIDTH must be a whole multiple of SLICE.
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;     // B, already inverted for subtraction
  logic [WIDTH-1:0] r_res;    // raw result, one slice per RUN edge
  logic             r_carry;  // carry between slices, seeded with sub
  logic             r_sat;
  logic [CW-1:0]    r_cnt;
  logic             r_cmsb;   // carry into the MSB
  logic             r_cout;   // carry out of the MSB

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_sl_sum;
  logic             w_cin_msb;
  logic             w_ovfl;
  logic [WIDTH-1:0] w_final;

  // Select the current slice of each operand and add it, including the carry-in.
  assign w_a_sl    = r_a[r_cnt*SLICE +: SLICE];
  assign w_b_sl    = r_bx[r_cnt*SLICE +: SLICE];
  assign w_sl_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
  assign w_cin_msb = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sl_sum[SLICE-1];

  // Overflow can only occur when the effective operand signs match, so A's sign picks the rail.
  assign w_ovfl  = r_cmsb ^ r_cout;
  assign w_final = (w_ovfl && r_sat) ? (r_a[WIDTH-1] ? MAX_NEG : MAX_POS) : r_res;

  // Control FSM: accept in IDLE, ripple the slices in RUN, publish the result in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_bx    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
      r_cmsb  <= 1'b0;
      r_cout  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Ovfl    <= 1'b0;
      Carry   <= 1'b0;
      Zero    <= 1'b0;
      Neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_bx    <= B ^ {WIDTH{sub}};
            r_carry <= sub;
            r_sat   <= sat_en;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res[r_cnt*SLICE +: SLICE] <= w_sl_sum[SLICE-1:0];
          r_carry <= w_sl_sum[SLICE];
          if (r_cnt == LAST_SLICE) begin
            r_cmsb  <= w_cin_msb;
            r_cout  <= w_sl_sum[SLICE];
            r_cnt   <= '0;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN: begin
          Sum     <= w_final;
          Ovfl    <= w_ovfl;
          Carry   <= r_cout;
          Zero    <= (w_final == '0);
          Neg     <= w_final[WIDTH-1];
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sat_seq.sv
// Directed testbench for addsub_sat_seq.
// Covers the 16/4 build plus 4/4 and 8/2 builds, with hand-computed expected results.
module tb_addsub_sat_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-bit slice instance
  logic        start = 1'b0, sub = 1'b0, sat_en = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        busy, done, Ovfl, Carry, Zero, Neg;
  logic [15:0] Sum;

  // 4-bit, single slice instance
  logic       s4_start = 1'b0, s4_sub = 1'b0, s4_sat = 1'b0;
  logic [3:0] s4_a = '0, s4_b = '0;
  logic       s4_busy, s4_done, s4_ovfl, s4_carry, s4_zero, s4_neg;
  logic [3:0] s4_sum;

  // 8-bit, 2-bit slice instance
  logic       s8_start = 1'b0, s8_sub = 1'b0, s8_sat = 1'b0;
  logic [7:0] s8_a = '0, s8_b = '0;
  logic       s8_busy, s8_done, s8_ovfl, s8_carry, s8_zero, s8_neg;
  logic [7:0] s8_sum;

  addsub_sat_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .sat_en(sat_en),
    .A(A), .B(B), .busy(busy), .done(done), .Sum(Sum),
    .Ovfl(Ovfl), .Carry(Carry), .Zero(Zero), .Neg(Neg));

  addsub_sat_seq #(.WIDTH(4), .SLICE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .sat_en(s4_sat),
    .A(s4_a), .B(s4_b), .busy(s4_busy), .done(s4_done), .Sum(s4_sum),
    .Ovfl(s4_ovfl), .Carry(s4_carry), .Zero(s4_zero), .Neg(s4_neg));

  addsub_sat_seq #(.WIDTH(8), .SLICE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub), .sat_en(s8_sat),
    .A(s8_a), .B(s8_b), .busy(s8_busy), .done(s8_done), .Sum(s8_sum),
    .Ovfl(s8_ovfl), .Carry(s8_carry), .Zero(s8_zero), .Neg(s8_neg));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one op on the 16-bit instance and wait for done, counting edges and busy cycles.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic sat, output int lat, output int bc);
    @(negedge clk);
    start = 1'b1; A = a; B = b; sub = s; sat_en = sat;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
  endtask

  task automatic do16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic sat, input logic [15:0] e_sum,
                      input logic e_o, input logic e_c, input logic e_z, input logic e_n);
    int lat, bc;
    op16(a, b, s, sat, lat, bc);
    $display("op %s: %h %s %h sat=%0d -> Sum=%h O=%0d C=%0d Z=%0d N=%0d lat=%0d",
             tag, a, s ? "-" : "+", b, sat, Sum, Ovfl, Carry, Zero, Neg, lat);
    check({tag, ".lat"},   lat,   5);
    check({tag, ".busy"},  bc,    5);
    check({tag, ".sum"},   Sum,   e_sum);
    check({tag, ".ovfl"},  Ovfl,  e_o);
    check({tag, ".carry"}, Carry, e_c);
    check({tag, ".zero"},  Zero,  e_z);
    check({tag, ".neg"},   Neg,   e_n);
  endtask

  initial begin
    int lat, bc, ndone;

    // Outputs must be cleared while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy",  busy,  0);
    check("rst.done",  done,  0);
    check("rst.sum",   Sum,   0);
    check("rst.ovfl",  Ovfl,  0);
    check("rst.carry", Carry, 0);
    check("rst.zero",  Zero,  0);
    check("rst.neg",   Neg,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add; done must be a single-cycle pulse.
    do16("add", 16'h1234, 16'h0101, 1'b0, 1'b1, 16'h1335, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("add.done_pulse", done, 0);

    // The following ops are issued back to back, each started on the edge that ends done.
    do16("pos_sat",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1, 0, 0, 0);
    do16("pos_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1, 0, 0, 1);
    do16("carry",    16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 0, 1, 1, 0);
    do16("sub_neg",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1, 1, 0, 1);
    do16("sub_min",  16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1, 0, 0, 0);
    do16("sub_eq",   16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 0, 1, 1, 0);

    // A start raised while busy must not disturb the op in flight.
    @(negedge clk);
    start = 1'b1; A = 16'h0001; B = 16'h0001; sub = 1'b0; sat_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; A = 16'h7000; B = 16'h7000;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op ignore: 0001 + 0001 (7000+7000 while busy) -> Sum=%h lat=%0d", Sum, lat);
    check("ignore.lat",  lat,  3);
    check("ignore.sum",  Sum,  16'h0002);
    check("ignore.ovfl", Ovfl, 0);
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ignore.extra_done", ndone, 0);
    check("ignore.busy", busy, 0);

    // Single-slice build: the result is ready two edges after start.
    @(negedge clk);
    s4_start = 1'b1; s4_a = 4'h7; s4_b = 4'h1; s4_sub = 1'b0; s4_sat = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    lat = 0;
    while (!s4_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op w4: 7 + 1 sat=1 -> Sum=%h O=%0d lat=%0d", s4_sum, s4_ovfl, lat);
    check("w4.lat",   lat,     2);
    check("w4.sum",   s4_sum,  4'h7);
    check("w4.ovfl",  s4_ovfl, 1);
    check("w4.carry", s4_carry, 0);

    // 8-bit build with 2-bit slices: negative overflow saturates.
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'h80; s8_b = 8'hFF; s8_sub = 1'b0; s8_sat = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    lat = 0;
    while (!s8_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op w8: 80 + FF sat=1 -> Sum=%h O=%0d C=%0d lat=%0d", s8_sum, s8_ovfl, s8_carry, lat);
    check("w8.lat",   lat,      5);
    check("w8.sum",   s8_sum,   8'h80);
    check("w8.ovfl",  s8_ovfl,  1);
    check("w8.carry", s8_carry, 1);
    check("w8.neg",   s8_neg,   1);

    // Reset in the middle of RUN aborts the op at once.
    @(negedge clk);
    start = 1'b1; A = 16'h1111; B = 16'h2222; sub = 1'b0; sat_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    $display("op abort: reset during RUN -> busy=%0d Sum=%h", busy, Sum);
    check("abort.busy", busy, 0);
    check("abort.sum",  Sum,  0);
    check("abort.done", done, 0);
    ndone = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort.no_done", ndone, 0);

    // The design recovers normally after the abort.
    do16("recover", 16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
